instr_ctrl_fsm: RTL and testbench

//   Instruction register, decoder and multicycle control FSM directly upstream of the 16-bit datapath.

---
 rtl/instr_ctrl_fsm.sv | 100 ++++++++++
 tb/tb_instr_ctrl_fsm.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_ctrl_fsm.sv
// instr_ctrl_fsm: instruction register, decoder and multicycle control FSM for the 16-bit datapath.
// Controls are registered from the next state and next IR, so they behave as Moore outputs of (state, IR).
module instr_ctrl_fsm #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              s,
    input  logic [DATA_W-1:0] in,
    output logic              w,
    output logic              bad_instr,
    output logic [REG_AW-1:0] readnum,
    output logic [REG_AW-1:0] writenum,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        vsel,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic [DATA_W-1:0] sximm8,
    output logic [DATA_W-1:0] sximm5,
    output logic              shift_ctrl
);
    typedef enum logic [2:0] {WAIT, DECODE, GETA, GETB, ALU, WREG, WIMM} state_t;
    state_t state, ns;
    logic [DATA_W-1:0] ir, ir_n;
    logic [2:0] opc;
    logic [1:0] op, sh;
    logic [REG_AW-1:0] rn, rd, rm;
    logic mov_imm, mov_reg, alu_cls, mvn, cmp;
    assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};
    assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};
    assign shift_ctrl = 1'b0;
    always_comb begin
        ir_n = (state == WAIT && load) ? in : ir;
        opc = ir_n[15:13];
        op = ir_n[12:11];
        rn = ir_n[10:8];
        rd = ir_n[7:5];
        sh = ir_n[4:3];
        rm = ir_n[2:0];
        mov_imm = opc == 3'b110 && op == 2'b10;
        mov_reg = opc == 3'b110 && op == 2'b00;
        alu_cls = opc == 3'b101;
        mvn = alu_cls && op == 2'b11;
        cmp = alu_cls && op == 2'b01;
        ns = WAIT;
        case (state)
            WAIT:    ns = s ? DECODE : WAIT;
            DECODE:  ns = mov_imm ? WIMM : (mov_reg || mvn) ? GETB : alu_cls ? GETA : WAIT;
            GETA:    ns = GETB;
            GETB:    ns = ALU;
            ALU:     ns = cmp ? WAIT : WREG;
            default: ns = WAIT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT;
            ir <= '0;
            w <= 1'b1;
            bad_instr <= 1'b0;
            readnum <= '0;
            writenum <= '0;
            write <= 1'b0;
            loada <= 1'b0;
            loadb <= 1'b0;
            loadc <= 1'b0;
            loads <= 1'b0;
            asel <= 1'b0;
            bsel <= 1'b0;
            vsel <= 2'd0;
            shift <= 2'd0;
            ALUop <= 2'd0;
        end else begin
            state <= ns;
            ir <= ir_n;
            w <= ns == WAIT;
            bad_instr <= ns == DECODE && !(mov_imm || mov_reg || alu_cls);
            readnum <= ns == GETA ? rn : ns == GETB ? rm : '0;
            writenum <= ns == WREG ? rd : ns == WIMM ? rn : '0;
            write <= ns == WREG || ns == WIMM;
            loada <= ns == GETA;
            loadb <= ns == GETB;
            loadc <= ns == ALU && !cmp;
            loads <= ns == ALU && cmp;
            asel <= ns == ALU && (mov_reg || mvn);
            bsel <= 1'b0;
            vsel <= ns == WIMM ? 2'd3 : 2'd0;
            shift <= ns == ALU ? sh : 2'd0;
            ALUop <= (ns == ALU && alu_cls) ? op : 2'd0;
        end
    end
endmodule

// File: tb/tb_instr_ctrl_fsm.sv
// tb_instr_ctrl_fsm: directed checks of instr_ctrl_fsm sequencing and decode.
module tb_instr_ctrl_fsm;
    logic clk = 0, reset = 1, load = 0, s = 0;
    logic [15:0] in = '0;
    logic w, bad_instr, write, loada, loadb, loadc, loads, asel, bsel, shift_ctrl;
    logic [2:0] readnum, writenum;
    logic [1:0] vsel, shift, ALUop;
    logic [15:0] sximm8, sximm5;
    int n_run = 0, n_fail = 0;

    instr_ctrl_fsm dut (
        .clk(clk), .reset(reset), .load(load), .s(s), .in(in), .w(w), .bad_instr(bad_instr),
        .readnum(readnum), .writenum(writenum), .write(write), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift),
        .ALUop(ALUop), .sximm8(sximm8), .sximm5(sximm5), .shift_ctrl(shift_ctrl)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_run++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ld(input logic [15:0] word);
        in = word;
        load = 1;
        tick();
        load = 0;
    endtask

    task automatic go();
        s = 1;
        tick();
        s = 0;
    endtask

    initial begin
        #1;
        tick();
        tick();
        chk("rst_w", w, 1);
        chk("rst_write", write, 0);
        chk("rst_readnum", readnum, 0);
        chk("rst_loada", loada, 0);
        chk("rst_ir", sximm8, 0);
        chk("rst_shift_ctrl", shift_ctrl, 0);
        reset = 0;
        tick();
        chk("idle_w", w, 1);
        // MOV R3,#42
        ld(16'hD32A);
        chk("movi_sximm8", sximm8, 16'd42);
        chk("movi_sximm5", sximm5, 16'h000A);
        go();
        chk("movi_dec_w", w, 0);
        chk("movi_dec_write", write, 0);
        chk("movi_dec_bad", bad_instr, 0);
        tick();
        chk("movi_write", write, 1);
        chk("movi_writenum", writenum, 3);
        chk("movi_vsel", vsel, 3);
        tick();
        chk("movi_done_w", w, 1);
        chk("movi_done_write", write, 0);
        // MOV R4,#-4
        ld(16'hD4FC);
        go();
        tick();
        chk("movn_sximm8", sximm8, 16'hFFFC);
        chk("movn_writenum", writenum, 4);
        chk("movn_write", write, 1);
        tick();
        // ADD R2,R5,R3
        ld(16'hA543);
        go();
        tick();
        chk("add_geta_readnum", readnum, 5);
        chk("add_geta_loada", loada, 1);
        chk("add_geta_loadb", loadb, 0);
        tick();
        chk("add_getb_readnum", readnum, 3);
        chk("add_getb_loadb", loadb, 1);
        chk("add_getb_loada", loada, 0);
        tick();
        chk("add_alu_op", ALUop, 0);
        chk("add_alu_asel", asel, 0);
        chk("add_alu_bsel", bsel, 0);
        chk("add_alu_loadc", loadc, 1);
        chk("add_alu_loads", loads, 0);
        tick();
        chk("add_wreg_writenum", writenum, 2);
        chk("add_wreg_write", write, 1);
        chk("add_wreg_vsel", vsel, 0);
        tick();
        chk("add_done_w", w, 1);
        // CMP R4,R6
        ld(16'hAC06);
        go();
        tick();
        chk("cmp_geta_readnum", readnum, 4);
        tick();
        chk("cmp_getb_readnum", readnum, 6);
        tick();
        chk("cmp_alu_op", ALUop, 1);
        chk("cmp_alu_loads", loads, 1);
        chk("cmp_alu_loadc", loadc, 0);
        chk("cmp_alu_write", write, 0);
        tick();
        chk("cmp_done_w", w, 1);
        chk("cmp_done_write", write, 0);
        // MVN R4,R0 skips GETA
        ld(16'hB880);
        go();
        tick();
        chk("mvn_getb_loadb", loadb, 1);
        chk("mvn_getb_loada", loada, 0);
        chk("mvn_getb_readnum", readnum, 0);
        tick();
        chk("mvn_alu_op", ALUop, 3);
        chk("mvn_alu_asel", asel, 1);
        tick();
        chk("mvn_wreg_writenum", writenum, 4);
        chk("mvn_wreg_write", write, 1);
        tick();
        // MOV R0,R4,ASR
        ld(16'hC01C);
        go();
        tick();
        chk("movr_getb_readnum", readnum, 4);
        tick();
        chk("movr_alu_shift", shift, 3);
        chk("movr_alu_asel", asel, 1);
        chk("movr_alu_op", ALUop, 0);
        tick();
        chk("movr_wreg_writenum", writenum, 0);
        chk("movr_wreg_write", write, 1);
        chk("movr_wreg_shift", shift, 0);
        tick();
        // unsupported opcode
        ld(16'hE000);
        go();
        chk("bad_pulse", bad_instr, 1);
        chk("bad_write", write, 0);
        tick();
        chk("bad_back_w", w, 1);
        chk("bad_clear", bad_instr, 0);
        // reset during GETB of ADD aborts
        ld(16'hA543);
        go();
        tick();
        tick();
        chk("abort_getb_loadb", loadb, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("abort_w", w, 1);
        chk("abort_loadb", loadb, 0);
        chk("abort_readnum", readnum, 0);
        tick();
        chk("abort_no_write", write, 0);
        chk("abort_idle_w", w, 1);
        // load outside WAIT is ignored
        ld(16'hD32A);
        go();
        in = 16'hE000;
        load = 1;
        tick();
        load = 0;
        chk("ign_sximm8", sximm8, 16'd42);
        chk("ign_writenum", writenum, 3);
        tick();
        chk("ign_after_sximm8", sximm8, 16'd42);
        chk("ign_after_w", w, 1);
        // load and s together decode the new word; s held starts the next one at once
        in = 16'hD4FC;
        load = 1;
        s = 1;
        tick();
        load = 0;
        chk("ls_dec_w", w, 0);
        tick();
        chk("ls_writenum", writenum, 4);
        chk("ls_write", write, 1);
        tick();
        chk("hold_wait_w", w, 1);
        tick();
        chk("hold_restart_w", w, 0);
        s = 0;
        tick();
        chk("hold_restart_write", write, 1);
        tick();
        chk("end_w", w, 1);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
